// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback sequencer: walks a synchronous instruction ROM,
// drives one-hot functional-unit enables, and emits a single write strobe per instruction.
module instr_sequencer #(
  parameter int PC_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [4:0]      imem_data,
  input  logic            unit_done,
  output logic            read_from,
  output logic            write_to,
  output logic            add_en,
  output logic            scale_en,
  output logic            mult_en,
  output logic            transpose_en,
  output logic            add_or_sub,
  output logic            wr_strobe,
  output logic            busy,
  output logic            halted,
  output logic            error,
  output logic [15:0]     instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WRITE, S_HALT
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_SCALE = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_TRANS = 3'b100;
  localparam logic [2:0] OP_STOP  = 3'b111;

  localparam logic [15:0]     WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [PC_W-1:0] PC_LAST   = '1;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [4:0]      ir_q, ir_d;
  logic [15:0]     wait_q, wait_d;
  logic [15:0]     count_q, count_d;
  logic            error_q, error_d;
  logic            read_from_q, read_from_d;
  logic            write_to_q, write_to_d;
  logic [3:0]      en_q, en_d;        // {transpose, mult, scale, add}
  logic            sub_q, sub_d;
  logic            wr_q, wr_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic [2:0]      opcode;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    wait_d      = wait_q;
    count_d     = count_q;
    error_d     = error_q;
    read_from_d = read_from_q;
    write_to_d  = write_to_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          count_d = '0;
          error_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d        = imem_data;
        read_from_d = imem_data[0];
        write_to_d  = imem_data[1];
        wait_d      = '0;
        case (imem_data[4:2])
          OP_ADD, OP_SUB, OP_SCALE, OP_MULT, OP_TRANS: state_d = S_EXEC;
          OP_STOP: state_d = S_HALT;
          default: begin
            error_d = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        // Completion wins over timeout when both land in the last allowed cycle.
        if (unit_done) begin
          state_d = S_WRITE;
        end else if (wait_q == WAIT_LAST) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_WRITE: begin
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        if (pc_q == PC_LAST) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with the state register.
    opcode = ir_d[4:2];
    en_d   = 4'b0000;
    sub_d  = 1'b0;
    if (state_d == S_EXEC) begin
      case (opcode)
        OP_ADD:   en_d = 4'b0001;
        OP_SUB:   begin en_d = 4'b0001; sub_d = 1'b1; end
        OP_SCALE: en_d = 4'b0010;
        OP_MULT:  en_d = 4'b0100;
        OP_TRANS: en_d = 4'b1000;
        default:  en_d = 4'b0000;
      endcase
    end
    wr_d     = (state_d == S_WRITE);
    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
               (state_d == S_EXEC)  || (state_d == S_WRITE);
    halted_d = (state_d == S_HALT);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      wait_q      <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      read_from_q <= 1'b0;
      write_to_q  <= 1'b0;
      en_q        <= '0;
      sub_q       <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      wait_q      <= wait_d;
      count_q     <= count_d;
      error_q     <= error_d;
      read_from_q <= read_from_d;
      write_to_q  <= write_to_d;
      en_q        <= en_d;
      sub_q       <= sub_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_addr    = pc_q;
  assign read_from    = read_from_q;
  assign write_to     = write_to_q;
  assign add_en       = en_q[0];
  assign scale_en     = en_q[1];
  assign mult_en      = en_q[2];
  assign transpose_en = en_q[3];
  assign add_or_sub   = sub_q;
  assign wr_strobe    = wr_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign error        = error_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a PC_W=4/TIMEOUT=8 instance driven through a write scoreboard,
// and a PC_W=2 instance for end-of-program and rerun behaviour.
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: PC_W=4, TIMEOUT=8
  logic       a_start, a_unit_done;
  logic [3:0] a_imem_addr;
  logic [4:0] a_imem_data;
  logic       a_read_from, a_write_to, a_add_en, a_scale_en, a_mult_en, a_transpose_en;
  logic       a_add_or_sub, a_wr_strobe, a_busy, a_halted, a_error;
  logic [15:0] a_instr_count;
  logic [4:0] a_rom [16];

  // Instance B: PC_W=2, TIMEOUT=255
  logic       b_start, b_unit_done;
  logic [1:0] b_imem_addr;
  logic [4:0] b_imem_data;
  logic       b_read_from, b_write_to, b_add_en, b_scale_en, b_mult_en, b_transpose_en;
  logic       b_add_or_sub, b_wr_strobe, b_busy, b_halted, b_error;
  logic [15:0] b_instr_count;
  logic [4:0] b_rom [4];

  always @(posedge clk) a_imem_data <= a_rom[a_imem_addr];
  always @(posedge clk) b_imem_data <= b_rom[b_imem_addr];

  instr_sequencer #(.PC_W(4), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .imem_addr(a_imem_addr),
    .imem_data(a_imem_data), .unit_done(a_unit_done), .read_from(a_read_from),
    .write_to(a_write_to), .add_en(a_add_en), .scale_en(a_scale_en),
    .mult_en(a_mult_en), .transpose_en(a_transpose_en), .add_or_sub(a_add_or_sub),
    .wr_strobe(a_wr_strobe), .busy(a_busy), .halted(a_halted), .error(a_error),
    .instr_count(a_instr_count)
  );

  instr_sequencer #(.PC_W(2), .TIMEOUT(255)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .imem_addr(b_imem_addr),
    .imem_data(b_imem_data), .unit_done(b_unit_done), .read_from(b_read_from),
    .write_to(b_write_to), .add_en(b_add_en), .scale_en(b_scale_en),
    .mult_en(b_mult_en), .transpose_en(b_transpose_en), .add_or_sub(b_add_or_sub),
    .wr_strobe(b_wr_strobe), .busy(b_busy), .halted(b_halted), .error(b_error),
    .instr_count(b_instr_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] en;   // {transpose, mult, scale, add}
    logic       sub;
    logic       wt;
    logic       rf;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a_stop();
    for (int i = 0; i < 16; i++) a_rom[i] = 5'b11100;
  endtask

  // Expected write for one instruction, derived from the opcode table.
  task automatic push_exp(input logic [4:0] ins, input int cyc);
    exp_t e;
    case (ins[4:2])
      3'b000, 3'b001: e.en = 4'b0001;
      3'b010:         e.en = 4'b0010;
      3'b011:         e.en = 4'b0100;
      3'b100:         e.en = 4'b1000;
      default:        e.en = 4'b0000;
    endcase
    e.sub = (ins[4:2] == 3'b001);
    e.wt  = ins[1];
    e.rf  = ins[0];
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Pulse start, answer enables with unit_done after lat enabled cycles (0 = never),
  // and compare each wr_strobe against the scoreboard. Returns the sample at which
  // halted was first seen (1 = first cycle after the start edge) and leftover enable cycles.
  task automatic run_a(input int lat, input int budget, output int halt_at, output int resid);
    logic [3:0] en, last_en;
    logic       last_sub;
    int         cyc;
    exp_t       e;
    cyc = 0; last_en = '0; last_sub = 1'b0; halt_at = -1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int t = 1; t <= budget; t++) begin
      en = {a_transpose_en, a_mult_en, a_scale_en, a_add_en};
      if (en != 4'b0000) begin
        cyc++;
        last_en  = en;
        last_sub = a_add_or_sub;
      end
      if (a_wr_strobe === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_wr_strobe: got strobe at sample %0d, expected none", t);
        end else begin
          e = sb.pop_front();
          n_checks += 4;
          if (last_en !== e.en) begin
            n_fail++; $display("FAIL wr_enable: got %b, expected %b", last_en, e.en);
          end
          if (last_sub !== e.sub) begin
            n_fail++; $display("FAIL wr_add_or_sub: got %b, expected %b", last_sub, e.sub);
          end
          if (cyc != e.cyc) begin
            n_fail++; $display("FAIL wr_exec_cycles: got %0d, expected %0d", cyc, e.cyc);
          end
          if ({a_write_to, a_read_from} !== {e.wt, e.rf}) begin
            n_fail++;
            $display("FAIL wr_steer: got wt/rf %b%b, expected %b%b",
                     a_write_to, a_read_from, e.wt, e.rf);
          end
        end
        cyc = 0;
      end
      if (a_halted === 1'b1) begin
        halt_at = t;
        break;
      end
      a_unit_done = (en != 4'b0000) && (lat != 0) && (cyc >= lat);
      tick();
    end
    a_unit_done = 1'b0;
    resid = cyc;
    n_checks++;
    if (halt_at < 0) begin
      n_fail++; $display("FAIL halt_timeout: got no halt within %0d cycles, expected halt", budget);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL missing_writes: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_start = 1'b0; a_unit_done = 1'b0;
    b_start = 1'b0; b_unit_done = 1'b0;
    fill_a_stop();
    for (int i = 0; i < 4; i++) b_rom[i] = 5'b11100;
    tick(); tick();
    n_checks++;
    if ({a_add_en, a_scale_en, a_mult_en, a_transpose_en, a_add_or_sub, a_wr_strobe,
         a_busy, a_halted, a_error, a_read_from, a_write_to} !== 11'b0) begin
      n_fail++; $display("FAIL reset_flags: got nonzero flags, expected all 0");
    end
    n_checks++;
    if ({a_imem_addr, a_instr_count} !== 20'h0) begin
      n_fail++; $display("FAIL reset_pc_count: got %h/%h, expected 0/0", a_imem_addr, a_instr_count);
    end
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if ({a_busy, a_halted, b_busy, b_halted} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy/halted %b%b, expected 00", a_busy, a_halted);
    end
  endtask

  task automatic test_single_add();
    int h, r;
    fill_a_stop();
    a_rom[0] = 5'b00011;
    push_exp(5'b00011, 2);
    run_a(2, 50, h, r);
    n_checks++;
    if (h != 8) begin n_fail++; $display("FAIL add_halt_cycle: got %0d, expected 8", h); end
    n_checks++;
    if ({a_error, a_instr_count} !== {1'b0, 16'd1}) begin
      n_fail++; $display("FAIL add_err_count: got %b/%0d, expected 0/1", a_error, a_instr_count);
    end
  endtask

  task automatic test_back_to_back();
    int h, r;
    logic [4:0] prog [4];
    prog[0] = 5'b00110; prog[1] = 5'b01001; prog[2] = 5'b01100; prog[3] = 5'b10011;
    fill_a_stop();
    for (int i = 0; i < 4; i++) begin
      a_rom[i] = prog[i];
      push_exp(prog[i], 1);
    end
    run_a(1, 60, h, r);
    n_checks++;
    if (h != 19) begin n_fail++; $display("FAIL b2b_halt_cycle: got %0d, expected 19", h); end
    n_checks++;
    if ({a_error, a_instr_count} !== {1'b0, 16'd4}) begin
      n_fail++; $display("FAIL b2b_err_count: got %b/%0d, expected 0/4", a_error, a_instr_count);
    end
  endtask

  task automatic test_illegal();
    int h, r;
    fill_a_stop();
    a_rom[0] = 5'b00000; a_rom[1] = 5'b01011; a_rom[2] = 5'b10100; a_rom[3] = 5'b00011;
    push_exp(5'b00000, 1);
    push_exp(5'b01011, 1);
    run_a(1, 60, h, r);
    n_checks++;
    if (h != 11) begin n_fail++; $display("FAIL illegal_halt_cycle: got %0d, expected 11", h); end
    n_checks++;
    if (r != 0) begin n_fail++; $display("FAIL illegal_enable: got %0d cycles, expected 0", r); end
    n_checks++;
    if ({a_error, a_instr_count} !== {1'b1, 16'd2}) begin
      n_fail++; $display("FAIL illegal_err_count: got %b/%0d, expected 1/2", a_error, a_instr_count);
    end
  endtask

  task automatic test_timeout();
    int h, r;
    fill_a_stop();
    a_rom[0] = 5'b01110;
    run_a(0, 60, h, r);
    n_checks++;
    if (r != 8) begin n_fail++; $display("FAIL timeout_mult_cycles: got %0d, expected 8", r); end
    n_checks++;
    if (h != 11) begin n_fail++; $display("FAIL timeout_halt_cycle: got %0d, expected 11", h); end
    n_checks++;
    if ({a_error, a_instr_count} !== {1'b1, 16'd0}) begin
      n_fail++; $display("FAIL timeout_err_count: got %b/%0d, expected 1/0", a_error, a_instr_count);
    end
  endtask

  task automatic test_reset_mid_exec();
    int seen;
    fill_a_stop();
    a_rom[0] = 5'b01000;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    seen = 0;
    for (int t = 0; t < 10 && seen == 0; t++) begin
      if (a_scale_en === 1'b1) seen = 1;
      else tick();
    end
    n_checks++;
    if (seen == 0) begin n_fail++; $display("FAIL scale_en_rise: got 0, expected 1 within 10 cycles"); end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({a_scale_en, a_busy, a_halted} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got scale_en/busy/halted %b%b%b, expected 000",
               a_scale_en, a_busy, a_halted);
    end
    #1 reset = 1'b0;
    a_unit_done = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_checks++;
      if ({a_busy, a_halted, a_wr_strobe, a_instr_count} !== 19'h0) begin
        n_fail++;
        $display("FAIL post_reset_idle: got busy/halted/wr %b%b%b count %0d, expected 000 count 0",
                 a_busy, a_halted, a_wr_strobe, a_instr_count);
      end
    end
    a_unit_done = 1'b0;
  endtask

  task automatic test_pc_no_wrap();
    int strobes, halt_at, wrapped, left0;
    for (int i = 0; i < 4; i++) b_rom[i] = 5'b10100;
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int t = 0; t < 10 && b_halted !== 1'b1; t++) tick();
    n_checks++;
    if ({b_halted, b_error} !== 2'b11) begin
      n_fail++; $display("FAIL b_illegal_first: got halted/error %b%b, expected 11", b_halted, b_error);
    end
    for (int i = 0; i < 4; i++) b_rom[i] = 5'b00011;
    b_start = 1'b1; tick(); b_start = 1'b0;
    n_checks++;
    if ({b_error, b_busy, b_imem_addr} !== {1'b0, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL b_rerun_start: got error/busy/addr %b%b%0d, expected 0 1 0",
               b_error, b_busy, b_imem_addr);
    end
    strobes = 0; halt_at = -1; wrapped = 0; left0 = 0;
    for (int t = 1; t <= 40; t++) begin
      if (b_imem_addr != 2'd0) left0 = 1;
      else if (left0 != 0) wrapped = 1;
      if (b_wr_strobe === 1'b1) strobes++;
      if (b_halted === 1'b1) begin halt_at = t; break; end
      b_unit_done = b_add_en;
      tick();
    end
    b_unit_done = 1'b0;
    n_checks++;
    if (strobes != 4) begin n_fail++; $display("FAIL b_strobes: got %0d, expected 4", strobes); end
    n_checks++;
    if (halt_at != 17) begin n_fail++; $display("FAIL b_halt_cycle: got %0d, expected 17", halt_at); end
    n_checks++;
    if ({b_error, b_instr_count} !== {1'b0, 16'd4}) begin
      n_fail++; $display("FAIL b_err_count: got %b/%0d, expected 0/4", b_error, b_instr_count);
    end
    tick(); tick();
    n_checks++;
    if (wrapped != 0 || b_imem_addr !== 2'd3 || b_halted !== 1'b1) begin
      n_fail++;
      $display("FAIL b_no_wrap: got wrapped=%0d addr=%0d halted=%b, expected 0 3 1",
               wrapped, b_imem_addr, b_halted);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid_exec();
    test_pc_no_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
